// File: rtl/pixel_frame_assembler.sv
// rtl/pixel_frame_assembler.sv - raster pixel stream into an R_I x C_I frame array
// Holds each completed frame stable until the consumer acknowledges it.
module pixel_frame_assembler #(
  parameter int R_I  = 16,
  parameter int C_I  = 16,
  parameter int W_I  = 8,
  parameter int FC_W = 16
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 s_sof,
  input  logic [W_I-1:0]                       s_data,
  output logic [R_I-1:0][C_I-1:0][W_I-1:0]     img,
  output logic                                 frame_valid,
  input  logic                                 frame_ack,
  output logic [FC_W-1:0]                      frame_cnt,
  output logic                                 err_sof
);

  localparam int RW = (R_I > 1) ? $clog2(R_I) : 1;
  localparam int CW = (C_I > 1) ? $clog2(C_I) : 1;
  localparam logic [RW-1:0]   ROW_LAST = RW'(R_I - 1);
  localparam logic [CW-1:0]   COL_LAST = CW'(C_I - 1);
  localparam logic [RW-1:0]   ROW_ONE  = RW'(1);
  localparam logic [CW-1:0]   COL_ONE  = CW'(1);
  localparam logic [FC_W-1:0] CNT_ONE  = FC_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t        state, state_d;
  logic [RW-1:0] row, row_d, wr_row;
  logic [CW-1:0] col, col_d, wr_col;
  logic          xfer, wr_en, cnt_inc, err_set;

  assign xfer        = s_valid & s_ready;
  assign frame_valid = (state == HOLD);

  always_comb begin
    state_d = state;
    row_d   = row;
    col_d   = col;
    wr_en   = 1'b0;
    wr_row  = row;
    wr_col  = col;
    cnt_inc = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        // Anything before a start-of-frame is drained without being stored.
        if (xfer && s_sof) begin
          wr_en   = 1'b1;
          wr_row  = '0;
          wr_col  = '0;
          row_d   = '0;
          col_d   = COL_ONE;
          state_d = FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (s_sof) begin
            // Restart wins even over the last pixel; the frame count is untouched.
            wr_row  = '0;
            wr_col  = '0;
            row_d   = '0;
            col_d   = COL_ONE;
            err_set = 1'b1;
          end else if (col == COL_LAST) begin
            col_d = '0;
            if (row == ROW_LAST) begin
              row_d   = '0;
              state_d = HOLD;
              cnt_inc = 1'b1;
            end else begin
              row_d = row + ROW_ONE;
            end
          end else begin
            col_d = col + COL_ONE;
          end
        end
      end
      HOLD: begin
        if (frame_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      s_ready   <= 1'b0;
      frame_cnt <= '0;
      err_sof   <= 1'b0;
    end else begin
      state   <= state_d;
      row     <= row_d;
      col     <= col_d;
      // Registered so ready stays low through reset and rises one cycle after it.
      s_ready <= (state_d != HOLD);
      if (cnt_inc) frame_cnt <= frame_cnt + CNT_ONE;
      if (err_set) err_sof <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      img <= '0;
    end else if (wr_en) begin
      img[wr_row][wr_col] <= s_data;
    end
  end

endmodule

// File: tb/tb_pixel_frame_assembler.sv
// tb/tb_pixel_frame_assembler.sv - scoreboard bench for pixel_frame_assembler
// Expected frames are queued as pixels are sent and popped when frame_valid rises.
module tb_pixel_frame_assembler;

  localparam int R  = 16;
  localparam int C  = 16;
  localparam int W  = 8;
  localparam int FW = 16;

  logic                       clk = 1'b0;
  logic                       rstn;
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_sof;
  logic [W-1:0]               s_data;
  logic [R-1:0][C-1:0][W-1:0] img;
  logic                       frame_valid;
  logic                       frame_ack;
  logic [FW-1:0]              frame_cnt;
  logic                       err_sof;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [R-1:0][C-1:0][W-1:0] img;
    logic [FW-1:0]              cnt;
    logic                       err;
  } frame_t;

  frame_t                     sb[$];
  logic [R-1:0][C-1:0][W-1:0] m_img;
  int                         m_idx;
  int                         m_state;   // 0 idle, 1 filling, 2 holding
  logic [FW-1:0]              m_cnt;
  logic                       m_err;

  pixel_frame_assembler #(.R_I(R), .C_I(C), .W_I(W), .FC_W(FW)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .img(img), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_cnt(frame_cnt), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: got timeout, required finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_img   = '0;
    m_idx   = 0;
    m_state = 0;
    m_cnt   = '0;
    m_err   = 1'b0;
    sb.delete();
  endtask

  task automatic model_xfer(input logic [W-1:0] d, input logic sof);
    frame_t f;
    if (sof && m_state != 2) begin
      if (m_state == 1) m_err = 1'b1;
      m_img[0][0] = d;
      m_idx       = 1;
      m_state     = 1;
    end else if (m_state == 1) begin
      m_img[4'(m_idx / C)][4'(m_idx % C)] = d;
      m_idx++;
      if (m_idx == R * C) begin
        m_idx   = 0;
        m_state = 2;
        m_cnt   = m_cnt + 16'd1;
        f.img   = m_img;
        f.cnt   = m_cnt;
        f.err   = m_err;
        sb.push_back(f);
      end
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic sof);
    int waitc = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    while (!s_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!s_ready) begin
      total++;
      $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
    end else begin
      @(posedge clk);
      model_xfer(d, sof);
    end
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic check_frame(input string name);
    frame_t f;
    bit     found = 0;
    @(negedge clk);
    total++;
    if (frame_valid !== 1'b1) $display("FAIL %s frame_valid: got %b required 1", name, frame_valid);
    else passed++;
    total++;
    if (s_ready !== 1'b0) $display("FAIL %s s_ready_hold: got %b required 0", name, s_ready);
    else passed++;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: got empty queue, required one frame", name);
    end else begin
      f = sb.pop_front();
      if (img !== f.img) begin
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            if (!found && img[r][c] !== f.img[r][c]) begin
              found = 1;
              $display("FAIL %s img[%0d][%0d]: got %h required %h", name, r, c, img[r][c], f.img[r][c]);
            end
      end else passed++;
      total++;
      if (frame_cnt !== f.cnt) $display("FAIL %s frame_cnt: got %0d required %0d", name, frame_cnt, f.cnt);
      else passed++;
      total++;
      if (err_sof !== f.err) $display("FAIL %s err_sof: got %b required %b", name, err_sof, f.err);
      else passed++;
    end
  endtask

  task automatic do_ack(input string name);
    @(negedge clk);
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    if (m_state == 2) m_state = 0;
    @(negedge clk);
    total++;
    if (frame_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL %s ack_release: got fv=%b rdy=%b required fv=0 rdy=1", name, frame_valid, s_ready);
    else passed++;
  endtask

  task automatic send_ramp_frame();
    for (int i = 0; i < R * C; i++) send(8'(i), i == 0);
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h5A; frame_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (img !== '0 || frame_valid !== 1'b0 || s_ready !== 1'b0 || frame_cnt !== '0 || err_sof !== 1'b0)
      $display("FAIL reset_state: got fv=%b rdy=%b cnt=%0d err=%b img_zero=%b required 0 0 0 0 1",
               frame_valid, s_ready, frame_cnt, err_sof, img === '0);
    else passed++;
    s_valid = 1'b0; s_sof = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) $display("FAIL reset_ready_rise: got %b required 1", s_ready);
    else passed++;
  endtask

  task automatic test_full_frame();
    bit ok = 1;
    send_ramp_frame();
    check_frame("full_frame");
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (img[r][c] !== 8'(r * 16 + c)) ok = 0;
    total++;
    if (!ok || frame_cnt !== 16'd1) $display("FAIL full_frame_ramp: got ok=%b cnt=%0d required ok=1 cnt=1", ok, frame_cnt);
    else passed++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h55;
    repeat (10) @(negedge clk);
    total++;
    if (img !== m_img || frame_valid !== 1'b1 || s_ready !== 1'b0 || frame_cnt !== 16'd1)
      $display("FAIL backpressure_hold: got fv=%b rdy=%b cnt=%0d img_same=%b required 1 0 1 1",
               frame_valid, s_ready, frame_cnt, img === m_img);
    else passed++;
    s_valid = 1'b0; s_sof = 1'b0;
    do_ack("backpressure");
    for (int i = 0; i < R * C; i++) send(8'(255 - i), i == 0);
    check_frame("backpressure_next");
  endtask

  task automatic test_early_sof();
    do_ack("early_sof_pre");
    for (int i = 0; i < 100; i++) send(8'(i + 3), i == 0);
    send(8'hAA, 1'b1);
    @(negedge clk);
    total++;
    if (img[0][0] !== 8'hAA || err_sof !== 1'b1 || frame_cnt !== 16'd2 || frame_valid !== 1'b0)
      $display("FAIL early_sof_restart: got px=%h err=%b cnt=%0d fv=%b required aa 1 2 0",
               img[0][0], err_sof, frame_cnt, frame_valid);
    else passed++;
    for (int i = 1; i < R * C; i++) send(8'(i ^ 8'h3C), 1'b0);
    check_frame("early_sof_frame");
  endtask

  task automatic test_drain();
    do_ack("drain_pre");
    for (int i = 0; i < 5; i++) send(8'h77, 1'b0);
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    total++;
    if (img !== m_img || frame_valid !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 16'd3)
      $display("FAIL drain_dropped: got fv=%b rdy=%b cnt=%0d img_same=%b required 0 1 3 1",
               frame_valid, s_ready, frame_cnt, img === m_img);
    else passed++;
    for (int i = 0; i < R * C; i++) send(8'(i * 7), i == 0);
    check_frame("drain_frame");
  endtask

  task automatic test_gaps_reset();
    bit ok = 1;
    do_ack("gaps_pre");
    for (int i = 0; i < R * C; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(8'(i), i == 0);
    end
    check_frame("gaps_frame");
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (img[r][c] !== 8'(r * 16 + c)) ok = 0;
    total++;
    if (!ok) $display("FAIL gaps_ramp: got mismatch required r*16+c");
    else passed++;
    do_ack("gaps_post");
    for (int i = 0; i < 50; i++) send(8'(i + 9), i == 0);
    @(negedge clk);
    s_valid = 1'b1; s_sof = 1'b1;
    #2 rstn = 1'b0;
    #1;
    total++;
    if (img !== '0 || frame_valid !== 1'b0 || s_ready !== 1'b0 || frame_cnt !== '0 || err_sof !== 1'b0)
      $display("FAIL midframe_reset: got fv=%b rdy=%b cnt=%0d err=%b img_zero=%b required 0 0 0 0 1",
               frame_valid, s_ready, frame_cnt, err_sof, img === '0);
    else passed++;
    model_reset();
    @(negedge clk);
    s_valid = 1'b0; s_sof = 1'b0;
    rstn = 1'b1;
    send(8'hEE, 1'b0);
    send_ramp_frame();
    check_frame("reset_recovery");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_early_sof();
    test_drain();
    test_gaps_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
